// File: rtl/target_route_sequencer.sv
// target_route_sequencer: steps a robot through a programmable waypoint table, presenting one {theta, r} location per leg to a planner.
// Ports: clk, reset (sync, active-high); switches (route start index), load (start-route pulse), cancel (abort route);
//        wr_en/wr_addr/wr_data ({last, theta, r}) program the table; loc_ready (planner handshake), arrived (waypoint reached pulse);
//        location/location_valid present the waypoint, route_index is the latched entry, busy and route_done report state.
// Macro TARGET_ROUTE_LOOP_EN: when defined, the final leg restarts the route at its start index instead of finishing.
module target_route_sequencer #(
  parameter int R_W = 8,
  parameter int THETA_W = 4,
  parameter int DEPTH = 8,
  parameter int IDX_W = 3,
  parameter logic [THETA_W+R_W-1:0] DEFAULT_LOCATION = (THETA_W+R_W)'({4'h6, 8'h18})
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [IDX_W-1:0]         switches,
  input  logic                     load,
  input  logic                     cancel,
  input  logic                     wr_en,
  input  logic [IDX_W-1:0]         wr_addr,
  input  logic [THETA_W+R_W:0]     wr_data,
  input  logic                     loc_ready,
  input  logic                     arrived,
  output logic [THETA_W+R_W-1:0]   location,
  output logic                     location_valid,
  output logic [IDX_W-1:0]         route_index,
  output logic                     busy,
  output logic                     route_done
);
  localparam int L = THETA_W + R_W;
  localparam logic [1:0] IDLE = 2'd0, PRESENT = 2'd1, TRAVEL = 2'd2, DONE = 2'd3;
`ifdef TARGET_ROUTE_LOOP_EN
  localparam bit LOOP_EN = 1'b1;
`else
  localparam bit LOOP_EN = 1'b0;
`endif
  logic [L:0]       tbl_q [DEPTH];
  logic [1:0]       state_q, state_d;
  logic [L-1:0]     loc_q, loc_d;
  logic             last_q, last_d;
  logic [IDX_W-1:0] idx_q, idx_d, start_q, start_d;
  logic [IDX_W:0]   legs_q, legs_d;
  logic             final_leg;
  // A leg is final on its latched last bit, or after DEPTH legs so an unterminated table cannot run forever.
  assign final_leg = last_q || legs_q == (IDX_W+1)'(DEPTH);
  always_comb begin
    state_d = state_q;
    loc_d = loc_q;
    last_d = last_q;
    idx_d = idx_q;
    start_d = start_q;
    legs_d = legs_q;
    if (cancel) state_d = IDLE;
    else if (load && (state_q == IDLE || state_q == DONE)) begin
      idx_d = switches;
      start_d = switches;
      legs_d = (IDX_W+1)'(1);
      {last_d, loc_d} = tbl_q[switches];
      state_d = PRESENT;
    end
    else if (state_q == PRESENT && loc_ready) state_d = TRAVEL;
    else if (state_q == TRAVEL && arrived) begin
      state_d = (final_leg && !LOOP_EN) ? DONE : PRESENT;
      if (state_d == PRESENT) begin
        idx_d = final_leg ? start_q : idx_q + IDX_W'(1);
        legs_d = final_leg ? (IDX_W+1)'(1) : legs_q + (IDX_W+1)'(1);
        {last_d, loc_d} = tbl_q[idx_d];
      end
    end
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      loc_q <= DEFAULT_LOCATION;
      last_q <= 1'b1;
      idx_q <= '0;
      start_q <= '0;
      legs_q <= '0;
    end else begin
      state_q <= state_d;
      loc_q <= loc_d;
      last_q <= last_d;
      idx_q <= idx_d;
      start_q <= start_d;
      legs_q <= legs_d;
    end
  end
  always_ff @(posedge clk) begin
    if (reset) for (int i = 0; i < DEPTH; i++) tbl_q[i] <= {1'b1, DEFAULT_LOCATION};
    else if (wr_en) tbl_q[wr_addr] <= wr_data;
  end
  assign location = loc_q;
  assign location_valid = state_q == PRESENT;
  assign route_index = idx_q;
  assign busy = state_q == PRESENT || state_q == TRAVEL;
  assign route_done = state_q == DONE;
endmodule

// File: tb/tb_target_route_sequencer.sv
// tb_target_route_sequencer: scoreboard bench for target_route_sequencer with directed routes.
module tb_target_route_sequencer;
`ifdef TARGET_ROUTE_LOOP_EN
  localparam bit LOOP = 1'b1;
`else
  localparam bit LOOP = 1'b0;
`endif
  logic clk = 0, reset = 1, load = 0, cancel = 0, wr_en = 0, loc_ready = 0, arrived = 0;
  logic [2:0] switches = 0, wr_addr = 0, route_index;
  logic [12:0] wr_data = 0;
  logic [11:0] location;
  logic location_valid, busy, route_done;
  logic [14:0] exp_q [$];
  int checks = 0, failures = 0;
  target_route_sequencer dut (
    .clk(clk), .reset(reset), .switches(switches), .load(load), .cancel(cancel),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data), .loc_ready(loc_ready), .arrived(arrived),
    .location(location), .location_valid(location_valid), .route_index(route_index),
    .busy(busy), .route_done(route_done)
  );
  always #5 clk = ~clk;
  initial begin
    #200000;
    $display("FAIL global_timeout");
    $fatal(1, "timeout");
  end
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic wr(input logic [2:0] a, input logic [12:0] d);
    wr_en = 1; wr_addr = a; wr_data = d;
    tick();
    wr_en = 0;
  endtask
  task automatic start(input logic [2:0] s);
    load = 1; switches = s;
    tick();
    load = 0;
  endtask
  task automatic stop();
    cancel = 1;
    tick();
    cancel = 0;
  endtask
  task automatic leg(input logic [11:0] l, input logic [2:0] ix);
    for (int n = 0; n < 20 && !location_valid; n++) tick();
    chk("wait_valid", location_valid, 1);
    exp_q.push_back({l, ix});
    loc_ready = 1;
    tick();
    loc_ready = 0;
    chk("travel_valid", location_valid, 0);
    chk("travel_busy", busy, 1);
    arrived = 1;
    tick();
    arrived = 0;
  endtask
  always @(negedge clk) begin
    if (location_valid && loc_ready) begin
      if (exp_q.size() == 0) chk("unexpected_handshake", 1, 0);
      else begin
        logic [14:0] e;
        e = exp_q.pop_front();
        chk("hs_location", location, e[14:3]);
        chk("hs_index", route_index, e[2:0]);
      end
    end
  end
  initial begin
    tick(); tick();
    chk("rst_location", location, 12'h618);
    chk("rst_valid", location_valid, 0);
    chk("rst_index", route_index, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", route_done, 0);
    reset = 0;
    start(0);
    chk("load_valid", location_valid, 1);
    chk("load_location", location, 12'h618);
    chk("load_index", route_index, 0);
    chk("load_busy", busy, 1);
    leg(12'h618, 0);
    chk("r1_done", route_done, !LOOP);
    chk("r1_valid", location_valid, LOOP);
    stop();
    chk("cancel_idle_busy", busy, 0);
    wr(6, {1'b0, 12'h120});
    wr(7, {1'b0, 12'h730});
    wr(0, {1'b1, 12'h80A});
    start(6);
    leg(12'h120, 6);
    leg(12'h730, 7);
    leg(12'h80A, 0);
    chk("r2_done", route_done, !LOOP);
    chk("r2_busy", busy, LOOP);
    stop();
    start(6);
    for (int i = 0; i < 10; i++) begin
      arrived = i[0];
      load = i == 3;
      switches = 0;
      wr_en = i == 5; wr_addr = 6; wr_data = {1'b0, 12'hB40};
      tick();
      chk("stall_location", location, 12'h120);
      chk("stall_valid", location_valid, 1);
      chk("stall_index", route_index, 6);
    end
    arrived = 0; load = 0; wr_en = 0;
    exp_q.push_back({12'h120, 3'd6});
    loc_ready = 1;
    tick();
    loc_ready = 0;
    cancel = 1; arrived = 1;
    tick();
    cancel = 0; arrived = 0;
    chk("cancel_busy", busy, 0);
    chk("cancel_done", route_done, 0);
    chk("cancel_valid", location_valid, 0);
    chk("cancel_location", location, 12'h120);
    start(6);
    chk("revisit_location", location, 12'hB40);
    stop();
    for (int i = 0; i < 8; i++) wr(3'(i), {1'b0, 12'(i * 12'h111)});
    start(0);
    for (int i = 0; i < 8; i++) leg(12'(i * 12'h111), 3'(i));
    chk("runaway_done", route_done, !LOOP);
    chk("runaway_valid", location_valid, LOOP);
    chk("runaway_index", route_index, LOOP ? 0 : 7);
    stop();
    start(2);
    chk("pre_reset_location", location, 12'h222);
    reset = 1;
    tick();
    reset = 0;
    chk("midreset_valid", location_valid, 0);
    chk("midreset_busy", busy, 0);
    chk("midreset_location", location, 12'h618);
    chk("midreset_index", route_index, 0);
    tick(); tick();
    chk("midreset_quiet", location_valid, 0);
    start(2);
    chk("table_reset_location", location, 12'h618);
    chk("table_reset_index", route_index, 2);
    stop();
    tick();
    chk("queue_empty", exp_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
